// File: rtl/bus_cycle_master.sv
// Multiplexed address/data bus master with T1/T2/T3/Tw/T4 cycles.
// All bus outputs decode from the registered state and captured request fields.
`timescale 1ns/1ps
module bus_cycle_master #(
    parameter int ADDR_WIDTH = 20,
    parameter int DATA_WIDTH = 8,
    parameter int MAX_WAIT   = 15
) (
    input  logic                  CLK,
    input  logic                  RESET,
    input  logic                  REQ,
    input  logic                  REQ_WR,
    input  logic                  REQ_IO,
    input  logic [ADDR_WIDTH-1:0] REQ_ADDR,
    input  logic [DATA_WIDTH-1:0] REQ_WDATA,
    output logic                  BUSY,
    output logic                  DONE,
    output logic                  ERR,
    output logic [DATA_WIDTH-1:0] RDATA,
    input  logic                  READY,
    output logic                  ALE,
    output logic                  IOM,
    output logic                  RD,
    output logic                  WR,
    output logic [ADDR_WIDTH-1:0] ADDRESS,
    inout  wire  [DATA_WIDTH-1:0] AD
);

    localparam int CNT_W = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);
    localparam logic [CNT_W-1:0] WAIT_LIMIT = CNT_W'(MAX_WAIT);

    typedef enum logic [2:0] {
        S_IDLE,
        S_T1,
        S_T2,
        S_T3,
        S_TW,
        S_T4
    } state_t;

    state_t                  state_q, state_d;
    logic                    wr_q, wr_d;
    logic                    io_q, io_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
    logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
    logic                    err_q, err_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic                    accept;
    logic                    strobe_phase;
    logic                    ad_oe;
    logic [DATA_WIDTH-1:0]   ad_out;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q <= S_IDLE;
            wr_q    <= 1'b0;
            io_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            wr_q    <= wr_d;
            io_q    <= io_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        wr_d    = wr_q;
        io_d    = io_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        cnt_d   = cnt_q;
        accept  = REQ && ((state_q == S_IDLE) || (state_q == S_T4));

        case (state_q)
            S_IDLE: begin
                if (REQ) begin
                    state_d = S_T1;
                end
            end
            S_T1: begin
                state_d = S_T2;
                cnt_d   = '0;
            end
            S_T2: begin
                state_d = S_T3;
            end
            S_T3, S_TW: begin
                // Timeout wins over READY so a stuck slave always terminates.
                if (cnt_q == WAIT_LIMIT) begin
                    state_d = S_T4;
                    err_d   = 1'b1;
                    rdata_d = '1;
                end else if (READY) begin
                    state_d = S_T4;
                    if (!wr_q) begin
                        rdata_d = AD;
                    end
                end else begin
                    state_d = S_TW;
                    cnt_d   = cnt_q + 1'b1;
                end
            end
            S_T4: begin
                state_d = REQ ? S_T1 : S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (accept) begin
            wr_d    = REQ_WR;
            io_d    = REQ_IO;
            addr_d  = REQ_ADDR;
            wdata_d = REQ_WDATA;
            err_d   = 1'b0;
        end
    end

    assign strobe_phase = (state_q == S_T2) || (state_q == S_T3) || (state_q == S_TW);

    // Write data stays on the bus through T4 for hold time; reads release it from T2 on.
    assign ad_oe  = (state_q == S_T1) || (wr_q && (strobe_phase || (state_q == S_T4)));
    assign ad_out = (state_q == S_T1) ? addr_q[DATA_WIDTH-1:0] : wdata_q;
    assign AD     = ad_oe ? ad_out : {DATA_WIDTH{1'bz}};

    assign BUSY    = (state_q != S_IDLE);
    assign DONE    = (state_q == S_T4);
    assign ALE     = (state_q == S_T1);
    assign IOM     = io_q;
    assign RD      = !(strobe_phase && !wr_q);
    assign WR      = !(strobe_phase && wr_q);
    assign ERR     = err_q;
    assign RDATA   = rdata_q;
    assign ADDRESS = addr_q;

endmodule
